// File: rtl/brg_gcd_xcel_pkg.sv
// Shared definitions for the GCD CSR accelerator: CSR word indices and FSM states.
package brg_gcd_xcel_pkg;

  localparam int CsrIdxW = 3;
  typedef logic [CsrIdxW-1:0] csr_idx_t;

  localparam csr_idx_t CSR_GO     = 3'd0;
  localparam csr_idx_t CSR_OPA    = 3'd1;
  localparam csr_idx_t CSR_OPB    = 3'd2;
  localparam csr_idx_t CSR_RESULT = 3'd3;
  localparam csr_idx_t CSR_STATUS = 3'd4;
  localparam csr_idx_t CSR_CYCLES = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/brg_gcd_xcel_dpath.sv
// Euclid-by-subtraction datapath: A/B working registers and a saturating cycle counter.
module brg_gcd_xcel_dpath
  import brg_gcd_xcel_pkg::*;
#(
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    load_i,
  input  logic [data_width_p-1:0] opa_i,
  input  logic [data_width_p-1:0] opb_i,
  input  logic                    step_i,
  output logic [data_width_p-1:0] a_o,
  output logic                    b_zero_o,
  output logic [data_width_p-1:0] cycles_o
);

  logic [data_width_p-1:0] a_q, a_d, b_q, b_d, cycles_q, cycles_d;

  assign a_o      = a_q;
  assign b_zero_o = (b_q == '0);
  assign cycles_o = cycles_q;

  // One Euclid step per cycle; the counter ticks on every CALC cycle, including the final one
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cycles_d = cycles_q;
    if (load_i) begin
      a_d      = opa_i;
      b_d      = opb_i;
      cycles_d = '0;
    end else if (step_i) begin
      cycles_d = (&cycles_q) ? cycles_q : cycles_q + data_width_p'(1);
      if (b_q == '0) begin
        a_d = a_q;
        b_d = b_q;
      end else if (a_q < b_q) begin
        a_d = b_q;
        b_d = a_q;
      end else begin
        a_d = a_q - b_q;
        b_d = b_q;
      end
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Working registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_q      <= '0;
      b_q      <= '0;
      cycles_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cycles_q <= cycles_d;
    end
  end

endmodule

// File: rtl/brg_slave_gcd_csr_xcel.sv
// Endpoint-facing GCD accelerator: CSR decode, byte-masked writes, control FSM, 1-cycle response.
module brg_slave_gcd_csr_xcel
  import brg_gcd_xcel_pkg::*;
#(
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 32,
  parameter int csr_idx_width_p = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      in_v_i,
  input  logic [addr_width_p-1:0]   in_addr_i,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic [data_width_p/8-1:0] in_mask_i,
  input  logic                      in_we_i,
  output logic                      in_yumi_o,
  output logic                      returning_v_o,
  output logic [data_width_p-1:0]   returning_data_o
);

  localparam int MaskW = data_width_p / 8;

  state_e                  state_q, state_d;
  logic [data_width_p-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [data_width_p-1:0] resp_data_q, resp_data_d, rd_data_s, a_s, cycles_s;
  logic                    done_q, done_d, resp_v_q, resp_v_d;
  logic                    busy_s, yumi_s, wr_s, go_s, load_s, b_zero_s, unused_addr_s;
  csr_idx_t                idx_s;

  function automatic logic [data_width_p-1:0] apply_mask(
    input logic [data_width_p-1:0] old_v,
    input logic [data_width_p-1:0] new_v,
    input logic [MaskW-1:0]        m
  );
    logic [data_width_p-1:0] r;
    r = old_v;
    for (int k = 0; k < MaskW; k++) begin
      if (m[k]) r[8*k +: 8] = new_v[8*k +: 8];
      else      r[8*k +: 8] = old_v[8*k +: 8];
    end
    return r;
  endfunction

  assign idx_s         = csr_idx_t'(in_addr_i[csr_idx_width_p-1:0]);
  assign unused_addr_s = ^in_addr_i[addr_width_p-1:csr_idx_width_p];
  assign busy_s        = (state_q == ST_CALC);
  // Only a RESULT read during CALC is held off; everything else is taken immediately
  assign yumi_s        = reset_n_i & in_v_i & ~((idx_s == CSR_RESULT) & ~in_we_i & busy_s);
  assign wr_s          = yumi_s & in_we_i;
  assign go_s          = wr_s & (idx_s == CSR_GO) & in_mask_i[0] & in_data_i[0];
  assign load_s        = go_s & ~busy_s;

  assign in_yumi_o        = yumi_s;
  assign returning_v_o    = resp_v_q;
  assign returning_data_o = resp_data_q;

  brg_gcd_xcel_dpath #(.data_width_p(data_width_p)) u_dpath (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (load_s),
    .opa_i    (opa_q),
    .opb_i    (opb_q),
    .step_i   (busy_s),
    .a_o      (a_s),
    .b_zero_o (b_zero_s),
    .cycles_o (cycles_s)
  );

  // CSR read mux
  always_comb begin
    rd_data_s = '0;
    case (idx_s)
      CSR_OPA:    rd_data_s = opa_q;
      CSR_OPB:    rd_data_s = opb_q;
      CSR_RESULT: rd_data_s = result_q;
      CSR_STATUS: begin
        rd_data_s[0] = busy_s;
        rd_data_s[1] = done_q;
      end
      CSR_CYCLES: rd_data_s = cycles_s;
      default:    rd_data_s = '0;
    endcase
  end

  // Next state for FSM, operand CSRs and the response register
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    result_d = result_q;
    if (wr_s && !busy_s && idx_s == CSR_OPA) opa_d = apply_mask(opa_q, in_data_i, in_mask_i);
    else                                     opa_d = opa_q;
    if (wr_s && !busy_s && idx_s == CSR_OPB) opb_d = apply_mask(opb_q, in_data_i, in_mask_i);
    else                                     opb_d = opb_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go_s) begin
          state_d = ST_CALC;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_CALC: begin
        if (b_zero_s) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = a_s;
        end else begin
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    resp_v_d = yumi_s;
    if (yumi_s && !in_we_i) resp_data_d = rd_data_s;
    else                    resp_data_d = '0;
  end

  // Control and CSR state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_brg_slave_gcd_csr_xcel.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor pops and compares.
module tb_brg_slave_gcd_csr_xcel;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_v, in_we, in_yumi, ret_v;
  logic [31:0] in_addr, in_data, ret_data;
  logic [3:0]  in_mask;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  brg_slave_gcd_csr_xcel dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .in_v_i          (in_v),
    .in_addr_i       (in_addr),
    .in_data_i       (in_data),
    .in_mask_i       (in_mask),
    .in_we_i         (in_we),
    .in_yumi_o       (in_yumi),
    .returning_v_o   (ret_v),
    .returning_data_o(ret_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Present one request, wait (bounded) for yumi, check stall length, queue expected response
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] mask, input logic [31:0] exp, input string nm,
                     input int exp_stall);
    int stall;
    @(negedge clk);
    in_v = 1'b1; in_we = we; in_addr = addr; in_data = data; in_mask = mask;
    stall = 0;
    #1;
    while (!in_yumi && stall < 50) begin
      @(negedge clk);
      #1;
      stall++;
    end
    chk({nm, " stall"}, 32'(stall), 32'(exp_stall));
    if (in_yumi) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset_n && ret_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got 0x%08h expected no response", ret_data);
      end else begin
        chk(name_q.pop_front(), ret_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_v = 1'b1; in_we = 1'b0; in_addr = 32'd4; in_data = 32'd0; in_mask = 4'h0;
    #3;
    chk("rst_yumi", {31'd0, in_yumi}, 32'd0);
    chk("rst_ret_v", {31'd0, ret_v}, 32'd0);
    chk("rst_ret_data", ret_data, 32'd0);
    in_v = 1'b0;
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;

    req(1'b0, 32'd4, 32'd0, 4'hF, 32'd0, "status_after_reset", 0);
    req(1'b0, 32'd5, 32'd0, 4'hF, 32'd0, "cycles_after_reset", 0);

    // 15,5: busy for 5 cycles
    req(1'b1, 32'd1, 32'd15, 4'hF, 32'd0, "wr_opa", 0);
    req(1'b1, 32'd2, 32'd5, 4'hF, 32'd0, "wr_opb", 0);
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "wr_go", 0);
    for (int i = 0; i < 5; i++) req(1'b0, 32'd4, 32'd0, 4'hF, 32'd1, "status_busy", 0);
    req(1'b0, 32'd4, 32'd0, 4'hF, 32'd2, "status_done", 0);
    req(1'b0, 32'd3, 32'd0, 4'hF, 32'd5, "result_15_5", 0);
    req(1'b0, 32'd5, 32'd0, 4'hF, 32'd5, "cycles_15_5", 0);

    // 0,7 and 0,0: RESULT read right after GO stalls for the whole CALC
    req(1'b1, 32'd1, 32'd0, 4'hF, 32'd0, "wr_opa0", 0);
    req(1'b1, 32'd2, 32'd7, 4'hF, 32'd0, "wr_opb7", 0);
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "go_0_7", 0);
    req(1'b0, 32'd3, 32'd0, 4'hF, 32'd7, "result_0_7", 2);
    req(1'b0, 32'd5, 32'd0, 4'hF, 32'd2, "cycles_0_7", 0);
    req(1'b1, 32'd2, 32'd0, 4'hF, 32'd0, "wr_opb0", 0);
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "go_0_0", 0);
    req(1'b0, 32'd3, 32'd0, 4'hF, 32'd0, "result_0_0", 1);
    req(1'b0, 32'd5, 32'd0, 4'hF, 32'd1, "cycles_0_0", 0);

    // Stalled RESULT read issued one cycle after GO
    req(1'b1, 32'd1, 32'd15, 4'hF, 32'd0, "wr_opa15", 0);
    req(1'b1, 32'd2, 32'd5, 4'hF, 32'd0, "wr_opb5", 0);
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "go_stall", 0);
    idle(1);
    req(1'b0, 32'd3, 32'd0, 4'hF, 32'd5, "result_stalled", 4);

    // OPA write and GO during CALC are acknowledged but dropped
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "go_again", 0);
    req(1'b1, 32'd1, 32'hFF, 4'hF, 32'd0, "wr_opa_calc", 0);
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "go_calc", 0);
    req(1'b0, 32'd3, 32'd0, 4'hF, 32'd5, "result_after_drop", 3);
    req(1'b0, 32'h0000_0101, 32'd0, 4'hF, 32'd15, "opa_unchanged", 0);
    req(1'b0, 32'd5, 32'd0, 4'hF, 32'd5, "cycles_no_restart", 0);

    // Byte mask and unmapped indices
    req(1'b1, 32'd1, 32'h1122_3344, 4'hF, 32'd0, "wr_opa_full", 0);
    req(1'b1, 32'd1, 32'hAABB_CCDD, 4'h2, 32'd0, "wr_opa_byte1", 0);
    req(1'b0, 32'd1, 32'd0, 4'hF, 32'h1122_CC44, "opa_masked", 0);
    req(1'b1, 32'd7, 32'hDEAD_BEEF, 4'hF, 32'd0, "wr_idx7", 0);
    req(1'b0, 32'd7, 32'd0, 4'hF, 32'd0, "rd_idx7", 0);
    req(1'b0, 32'd6, 32'd0, 4'hF, 32'd0, "rd_idx6", 0);
    req(1'b0, 32'd0, 32'd0, 4'hF, 32'd0, "rd_go", 0);

    // Reset in the middle of a long computation
    req(1'b1, 32'd0, 32'd1, 4'hF, 32'd0, "go_long", 0);
    idle(2);
    @(negedge clk);
    in_v = 1'b1; in_we = 1'b0; in_addr = 32'd4;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_yumi", {31'd0, in_yumi}, 32'd0);
    chk("midrst_ret_v", {31'd0, ret_v}, 32'd0);
    chk("midrst_ret_data", ret_data, 32'd0);
    in_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req(1'b0, 32'd4, 32'd0, 4'hF, 32'd0, "status_post_rst", 0);
    req(1'b0, 32'd3, 32'd0, 4'hF, 32'd0, "result_post_rst", 0);
    req(1'b0, 32'd1, 32'd0, 4'hF, 32'd0, "opa_post_rst", 0);
    req(1'b0, 32'd5, 32'd0, 4'hF, 32'd0, "cycles_post_rst", 0);

    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
